// File: rtl/masked_present_nibble_seq_pkg.sv
// rtl/masked_present_nibble_seq_pkg.sv - shared types, FSM states and the PRESENT bit permutation
package masked_present_pkg;

    localparam int NIB    = 16;
    localparam int SHARES = 3;

    typedef logic [63:0] state_share_t;
    typedef logic [3:0]  nibble_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } seq_state_e;

    // bit i moves to 16*i mod 63; bit 63 stays put
    function automatic state_share_t player(input state_share_t x);
        state_share_t y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(16 * i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/masked_present_nibble_seq_if.sv
// rtl/masked_present_nibble_seq_if.sv - randomness stream and external masked S-box bus
interface masked_present_nibble_seq_if;
    import masked_present_pkg::*;

    logic [7:0] rnd_i;
    logic       rnd_valid_i;
    logic       rnd_ready_o;
    nibble_t    sbox_in1_o;
    nibble_t    sbox_in2_o;
    nibble_t    sbox_in3_o;
    logic [7:0] sbox_r_o;
    nibble_t    sbox_out1_i;
    nibble_t    sbox_out2_i;
    nibble_t    sbox_out3_i;

    modport master (
        input  rnd_i, rnd_valid_i, sbox_out1_i, sbox_out2_i, sbox_out3_i,
        output rnd_ready_o, sbox_in1_o, sbox_in2_o, sbox_in3_o, sbox_r_o
    );

    modport slave (
        output rnd_i, rnd_valid_i, sbox_out1_i, sbox_out2_i, sbox_out3_i,
        input  rnd_ready_o, sbox_in1_o, sbox_in2_o, sbox_in3_o, sbox_r_o
    );

endinterface

// File: rtl/masked_present_nibble_seq_player.sv
// rtl/masked_present_nibble_seq_player.sv - combinational pLayer applied to a single share
module present_player_share
    import masked_present_pkg::*;
(
    input  state_share_t i_x,
    output state_share_t o_y
);

    assign o_y = player(i_x);

endmodule

// File: rtl/masked_present_nibble_seq.sv
// rtl/masked_present_nibble_seq.sv - nibble-serial round sequencer around an external 3-share masked S-box
// Optional build macro MASKED_PRESENT_ZEROIZE_EN clears buffers after each round and quiets idle S-box ports.
module masked_present_nibble_seq
    import masked_present_pkg::*;
#(
    parameter int SBOX_LAT = 4,
    parameter int RND_OFS  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  state_share_t                  st1_i,
    input  state_share_t                  st2_i,
    input  state_share_t                  st3_i,
    input  state_share_t                  rk1_i,
    input  state_share_t                  rk2_i,
    input  state_share_t                  rk3_i,
    output state_share_t                  st1_o,
    output state_share_t                  st2_o,
    output state_share_t                  st3_o,
    masked_present_nibble_seq_if.master   bus
);

    seq_state_e                  r_state;
    seq_state_e                  w_state_nxt;
    logic                        w_busy;
    logic                        w_done;
    logic                        w_ready;

    state_share_t                r_work  [SHARES];
    state_share_t                r_res   [SHARES];
    state_share_t                r_st_o  [SHARES];
    state_share_t                w_res_nxt [SHARES];
    state_share_t                w_pl    [SHARES];
    state_share_t                w_st_i  [SHARES];
    state_share_t                w_rk_i  [SHARES];
    nibble_t                     w_sout  [SHARES];
    nibble_t                     w_sin   [SHARES];
    nibble_t                     w_sin_o [SHARES];

    logic [3:0]                  r_idx;
    logic [3:0]                  r_ret;
    logic [SBOX_LAT-1:0]         r_vld;
    logic [RND_OFS-1:0][7:0]     r_rnd_dl;

    logic                        w_issue;
    logic                        w_ret;
    logic [7:0]                  w_rnd_in;

    assign w_st_i[0] = st1_i;
    assign w_st_i[1] = st2_i;
    assign w_st_i[2] = st3_i;
    assign w_rk_i[0] = rk1_i;
    assign w_rk_i[1] = rk2_i;
    assign w_rk_i[2] = rk3_i;
    assign w_sout[0] = bus.sbox_out1_i;
    assign w_sout[1] = bus.sbox_out2_i;
    assign w_sout[2] = bus.sbox_out3_i;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_busy  = 1'b1;
                w_ready = 1'b1;
                if (bus.rnd_valid_i && (r_idx == 4'(NIB - 1))) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_ret && (r_ret == 4'(NIB - 1))) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_issue  = w_ready & bus.rnd_valid_i;
    assign w_ret    = r_vld[SBOX_LAT-1];
    assign w_rnd_in = w_issue ? bus.rnd_i : 8'h00;

    // A bubble puts all-zero shares on the S-box so it can free-run without stalls
    always_comb begin
        for (int k = 0; k < SHARES; k++) begin
            w_sin[k]     = w_issue ? r_work[k][{r_idx, 2'b00} +: 4] : 4'h0;
            w_res_nxt[k] = r_res[k];
            if (w_ret) w_res_nxt[k][{r_ret, 2'b00} +: 4] = w_sout[k];
        end
    end

    for (genvar g = 0; g < SHARES; g++) begin : g_player
        present_player_share u_player (
            .i_x (w_res_nxt[g]),
            .o_y (w_pl[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_ret    <= '0;
            r_vld    <= '0;
            r_rnd_dl <= '0;
            for (int k = 0; k < SHARES; k++) begin
                r_work[k] <= '0;
                r_res[k]  <= '0;
                r_st_o[k] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_vld    <= {r_vld[SBOX_LAT-2:0], w_issue};
            r_rnd_dl <= {r_rnd_dl[RND_OFS-2:0], w_rnd_in};
            if (r_state == S_IDLE && start_i) begin
                r_idx <= '0;
                r_ret <= '0;
                for (int k = 0; k < SHARES; k++) r_work[k] <= w_st_i[k] ^ w_rk_i[k];
            end
            if (w_issue) r_idx <= r_idx + 4'd1;
            if (w_ret) begin
                r_ret <= r_ret + 4'd1;
                for (int k = 0; k < SHARES; k++) r_res[k] <= w_res_nxt[k];
            end
            if (r_state == S_DRAIN && w_ret && (r_ret == 4'(NIB - 1))) begin
                for (int k = 0; k < SHARES; k++) r_st_o[k] <= w_pl[k];
            end
`ifdef MASKED_PRESENT_ZEROIZE_EN
            if (r_state == S_DONE) begin
                for (int k = 0; k < SHARES; k++) begin
                    r_work[k] <= '0;
                    r_res[k]  <= '0;
                end
            end
`endif
        end
    end

`ifdef MASKED_PRESENT_ZEROIZE_EN
    always_comb begin
        for (int k = 0; k < SHARES; k++) w_sin_o[k] = w_ready ? w_sin[k] : 4'h0;
    end
    assign bus.sbox_r_o = w_ready ? r_rnd_dl[RND_OFS-1] : 8'h00;
`else
    nibble_t r_hold [SHARES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHARES; k++) r_hold[k] <= '0;
        end else if (w_ready) begin
            for (int k = 0; k < SHARES; k++) r_hold[k] <= w_sin[k];
        end
    end

    always_comb begin
        for (int k = 0; k < SHARES; k++) w_sin_o[k] = w_ready ? w_sin[k] : r_hold[k];
    end
    assign bus.sbox_r_o = r_rnd_dl[RND_OFS-1];
`endif

    assign bus.sbox_in1_o  = w_sin_o[0];
    assign bus.sbox_in2_o  = w_sin_o[1];
    assign bus.sbox_in3_o  = w_sin_o[2];
    assign bus.rnd_ready_o = w_ready;
    assign busy_o          = w_busy;
    assign done_o          = w_done;
    assign st1_o           = r_st_o[0];
    assign st2_o           = r_st_o[1];
    assign st3_o           = r_st_o[2];

endmodule

// File: tb/tb_masked_present_nibble_seq.sv
// tb/tb_masked_present_nibble_seq.sv - directed bench with a behavioural 3-share S-box alongside the sequencer
module tb_masked_present_nibble_seq;
    import masked_present_pkg::*;

`ifdef MASKED_PRESENT_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    localparam logic [63:0] PT      = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PT_EXP  = 64'h9B70_E16C_32E5_59A6;
    localparam logic [63:0] ZERO_EXP = 64'hFFFF_FFFF_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [63:0] st1_i = '0, st2_i = '0, st3_i = '0;
    logic [63:0] rk1_i = '0, rk2_i = '0, rk3_i = '0;
    logic [63:0] st1_o, st2_o, st3_o;

    int total = 0;
    int bad   = 0;

    masked_present_nibble_seq_if sif ();

    masked_present_nibble_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .st1_i   (st1_i),
        .st2_i   (st2_i),
        .st3_i   (st3_i),
        .rk1_i   (rk1_i),
        .rk2_i   (rk2_i),
        .rk3_i   (rk3_i),
        .st1_o   (st1_o),
        .st2_o   (st2_o),
        .st3_o   (st3_o),
        .bus     (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox_f(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    // S-box model: inputs held two stages, r taken on the third cycle, outputs two stages later
    logic [3:0] p1a = '0, p2a = '0, p3a = '0, p1b = '0, p2b = '0, p3b = '0;
    logic [3:0] q1a = '0, q2a = '0, q3a = '0, q1b = '0, q2b = '0, q3b = '0;

    always @(posedge clk) begin
        p1a <= sif.sbox_in1_o;  p2a <= sif.sbox_in2_o;  p3a <= sif.sbox_in3_o;
        p1b <= p1a;             p2b <= p2a;             p3b <= p3a;
        q1a <= p1b ^ sif.sbox_r_o[3:0];
        q2a <= p2b ^ sif.sbox_r_o[7:4];
        q3a <= sbox_f(p1b ^ p2b ^ p3b) ^ p1b ^ p2b ^ sif.sbox_r_o[3:0] ^ sif.sbox_r_o[7:4];
        q1b <= q1a;             q2b <= q2a;             q3b <= q3a;
    end

    assign sif.sbox_out1_i = q1b;
    assign sif.sbox_out2_i = q2b;
    assign sif.sbox_out3_i = q3b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_round(input logic [63:0] s1, s2, s3, k1, k2, k3,
                             input bit starve, input bit hold,
                             output int done_cyc, output int nbub);
        int         cyc;
        int         issues;
        int         berr;
        int         q_cyc [$];
        logic [7:0] q_byte [$];
        logic [7:0] exp_r;
        st1_i = s1;  st2_i = s2;  st3_i = s3;
        rk1_i = k1;  rk2_i = k2;  rk3_i = k3;
        start_i = 1'b1;
        sif.rnd_valid_i = 1'b1;
        sif.rnd_i = 8'($urandom);
        cyc = 0;  issues = 0;  nbub = 0;  berr = 0;  done_cyc = -1;
        while (done_cyc < 0 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) start_i = 1'b0;
            sif.rnd_valid_i = !(starve && issues == 5 && nbub < 3);
            sif.rnd_i = 8'($urandom);
            @(negedge clk);
            if (q_cyc.size() > 0 && q_cyc[0] + 2 == cyc) begin
                exp_r = (ZEROIZE && !sif.rnd_ready_o) ? 8'h00 : q_byte[0];
                chk("r_align", 64'(sif.sbox_r_o), 64'(exp_r));
                void'(q_cyc.pop_front());
                void'(q_byte.pop_front());
            end
            if (sif.rnd_ready_o && sif.rnd_valid_i) begin
                issues++;
                q_cyc.push_back(cyc);
                q_byte.push_back(sif.rnd_i);
            end else if (sif.rnd_ready_o) begin
                nbub++;
                chk("bubble_in", 64'({sif.sbox_in1_o, sif.sbox_in2_o, sif.sbox_in3_o}), 64'h0);
            end
            if (busy_o !== !done_o) berr++;
            if (done_o) done_cyc = cyc;
        end
        chk("busy_seq", 64'(berr), 64'd0);
        if (done_cyc < 0) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        int          dc;
        int          nb;
        logic [63:0] a, b, k1, k2, k3;

        sif.rnd_i = '0;
        sif.rnd_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_done",  64'(done_o), 64'd0);
        chk("rst_ready", 64'(sif.rnd_ready_o), 64'd0);
        chk("rst_r",     64'(sif.sbox_r_o), 64'd0);
        chk("rst_sin",   64'({sif.sbox_in1_o, sif.sbox_in2_o, sif.sbox_in3_o}), 64'd0);
        chk("rst_st",    st1_o | st2_o | st3_o, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_round('0, '0, '0, '0, '0, '0, 1'b0, 1'b0, dc, nb);
        chk("zero_done_cyc", 64'(dc), 64'd21);
        chk("zero_xor", st1_o ^ st2_o ^ st3_o, ZERO_EXP);
        @(posedge clk);
        #1;

        for (int s = 0; s < 1000; s++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            k1 = {$urandom, $urandom};
            k2 = {$urandom, $urandom};
            k3 = {$urandom, $urandom};
            run_round(a, b, PT ^ a ^ b ^ k1 ^ k2 ^ k3, k1, k2, k3, 1'b0, 1'b0, dc, nb);
            chk("rand_xor", st1_o ^ st2_o ^ st3_o, PT_EXP);
            if (s == 0) chk("rand_done_cyc", 64'(dc), 64'd21);
            @(posedge clk);
            #1;
        end

        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        run_round(a, b, PT ^ a ^ b, '0, '0, '0, 1'b1, 1'b0, dc, nb);
        chk("starve_done_cyc", 64'(dc), 64'd24);
        chk("starve_bubbles", 64'(nb), 64'd3);
        chk("starve_xor", st1_o ^ st2_o ^ st3_o, PT_EXP);
        @(posedge clk);
        #1;

        run_round('0, '0, '0, '0, '0, '0, 1'b0, 1'b1, dc, nb);
        chk("hold_done_cyc", 64'(dc), 64'd21);
        chk("hold_xor", st1_o ^ st2_o ^ st3_o, ZERO_EXP);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("hold_no_relaunch", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        sif.rnd_valid_i = 1'b0;
        @(negedge clk);
        chk("hold_idle_busy", 64'(busy_o), 64'd0);
        chk("hold_idle_done", 64'(done_o), 64'd0);
`ifdef MASKED_PRESENT_ZEROIZE_EN
        chk("zeroize_sin", 64'({sif.sbox_in1_o, sif.sbox_in2_o, sif.sbox_in3_o}), 64'd0);
        chk("zeroize_work", dut.r_work[0] | dut.r_work[1] | dut.r_work[2], 64'd0);
        chk("zeroize_res", dut.r_res[0] | dut.r_res[1] | dut.r_res[2], 64'd0);
`endif
        @(posedge clk);
        #1;

        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        st1_i = a;  st2_i = b;  st3_i = PT ^ a ^ b;
        rk1_i = '0; rk2_i = '0; rk3_i = '0;
        start_i = 1'b1;
        sif.rnd_valid_i = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            sif.rnd_i = 8'($urandom);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(busy_o), 64'd0);
        chk("mid_rst_ready", 64'(sif.rnd_ready_o), 64'd0);
        chk("mid_rst_sin",   64'({sif.sbox_in1_o, sif.sbox_in2_o, sif.sbox_in3_o}), 64'd0);
        chk("mid_rst_r",     64'(sif.sbox_r_o), 64'd0);
        chk("mid_rst_st",    st1_o | st2_o | st3_o, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        run_round(a, b, PT ^ a ^ b, '0, '0, '0, 1'b0, 1'b0, dc, nb);
        chk("post_rst_done_cyc", 64'(dc), 64'd21);
        chk("post_rst_xor", st1_o ^ st2_o ^ st3_o, PT_EXP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
